// File: rtl/issue_scheduler_if.sv
// Bundle of decoder, dispatch, writeback and status signals around the issue scheduler.
// The master modport is the scheduler's view; the slave modport is its environment.
interface issue_scheduler_if #(
   parameter int CNT_W = 16
);
   logic             dec_valid_i;
   logic             dec_ready_o;
   logic [3:0]       dec_type_i;
   logic [4:0]       dec_rd_i;
   logic [4:0]       dec_rs1_i;
   logic [4:0]       dec_rs2_i;
   logic [4:0]       dec_rs3_i;
   logic [2:0]       dec_rconf_i;
   logic             dec_n_bad_i;
   logic             flush_i;
   logic             alu_valid_o;
   logic             alu_ready_i;
   logic             fpu_valid_o;
   logic             fpu_ready_i;
   logic             mem_valid_o;
   logic             mem_ready_i;
   logic [3:0]       iss_type_o;
   logic [4:0]       iss_rd_o;
   logic [4:0]       iss_rs1_o;
   logic [4:0]       iss_rs2_o;
   logic [4:0]       iss_rs3_o;
   logic             wb_int_valid_i;
   logic [4:0]       wb_int_rd_i;
   logic             wb_fp_valid_i;
   logic [4:0]       wb_fp_rd_i;
   logic             trap_valid_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport master (
      input  dec_valid_i, dec_type_i, dec_rd_i, dec_rs1_i, dec_rs2_i, dec_rs3_i,
      input  dec_rconf_i, dec_n_bad_i, flush_i,
      input  alu_ready_i, fpu_ready_i, mem_ready_i,
      input  wb_int_valid_i, wb_int_rd_i, wb_fp_valid_i, wb_fp_rd_i,
      output dec_ready_o, alu_valid_o, fpu_valid_o, mem_valid_o,
      output iss_type_o, iss_rd_o, iss_rs1_o, iss_rs2_o, iss_rs3_o,
      output trap_valid_o, stall_cnt_o
   );

   modport slave (
      output dec_valid_i, dec_type_i, dec_rd_i, dec_rs1_i, dec_rs2_i, dec_rs3_i,
      output dec_rconf_i, dec_n_bad_i, flush_i,
      output alu_ready_i, fpu_ready_i, mem_ready_i,
      output wb_int_valid_i, wb_int_rd_i, wb_fp_valid_i, wb_fp_rd_i,
      input  dec_ready_o, alu_valid_o, fpu_valid_o, mem_valid_o,
      input  iss_type_o, iss_rd_o, iss_rs1_o, iss_rs2_o, iss_rs3_o,
      input  trap_valid_o, stall_cnt_o
   );
endinterface

// File: rtl/issue_scheduler.sv
// Single-issue in-order dispatch controller.
// Holds one decoded instruction, waits until its integer/FP scoreboard hazards
// clear, then hands it to the ALU, FPU or MEM unit over valid/ready.
module issue_scheduler #(
   parameter int CNT_W   = 16,
   parameter bit X0_HARD = 1'b1
) (
   input logic                clk,
   input logic                n_rst,
   issue_scheduler_if.master  bus
);

   typedef enum logic [1:0] {EMPTY, WAIT, ISSUE, TRAP} state_t;

   state_t           state_q;
   logic [3:0]       issType_q;
   logic [4:0]       issRd_q;
   logic [4:0]       issRs1_q;
   logic [4:0]       issRs2_q;
   logic [4:0]       issRs3_q;
   logic [2:0]       issRconf_q;
   logic [CNT_W-1:0] stallCnt_q;
   logic [31:0]      busyInt_q;
   logic [31:0]      busyFp_q;
   logic [31:0]      busyInt_d;
   logic [31:0]      busyFp_d;

   logic isMem, isFpu, isAlu;
   logic selMem, selFpu, selAlu;
   logic rdFp, rs1Fp, rs23Fp;
   logic rs1Busy, rs2Busy, rs3Busy, rdBusy;
   logic hazard;
   logic unitReady;
   logic handshake;
   logic decBad;

   // Decode the held instruction: unit priority MEM > FPU > ALU, and which
   // register file each operand lives in (FP loads keep an integer base).
   always_comb begin
      isMem   = issType_q[0];
      isFpu   = issType_q[2];
      isAlu   = issType_q[3];
      selMem  = isMem;
      selFpu  = !isMem && isFpu;
      selAlu  = !isMem && !isFpu && isAlu;
      rdFp    = isFpu;
      rs1Fp   = !isMem && isFpu;
      rs23Fp  = isFpu;
      rs1Busy = rs1Fp  ? busyFp_q[issRs1_q] : busyInt_q[issRs1_q];
      rs2Busy = rs23Fp ? busyFp_q[issRs2_q] : busyInt_q[issRs2_q];
      rs3Busy = rs23Fp ? busyFp_q[issRs3_q] : busyInt_q[issRs3_q];
      rdBusy  = rdFp   ? busyFp_q[issRd_q]  : busyInt_q[issRd_q];
      hazard  = (issRconf_q[2] && rs1Busy) || (issRconf_q[1] && rs2Busy)
             || (issRconf_q[0] && rs3Busy) || rdBusy;
      unitReady = (selMem && bus.mem_ready_i) || (selFpu && bus.fpu_ready_i)
               || (selAlu && bus.alu_ready_i);
      handshake = (state_q == ISSUE) && unitReady;
   end

   // An incoming instruction is bad if flagged by the decoder or if it names
   // no execution unit (fpu_sd alone, or an all-zero type, has nowhere to go).
   always_comb begin
      decBad = !bus.dec_n_bad_i || ((bus.dec_type_i & 4'b1101) == 4'b0000);
   end

   // Scoreboard next state: writebacks clear first, then an issue handshake
   // sets its destination so a same-register set beats the clear.
   always_comb begin
      busyInt_d = busyInt_q;
      busyFp_d  = busyFp_q;
      if (bus.wb_int_valid_i && !(X0_HARD && bus.wb_int_rd_i == 5'd0))
         busyInt_d[bus.wb_int_rd_i] = 1'b0;
      if (bus.wb_fp_valid_i)
         busyFp_d[bus.wb_fp_rd_i] = 1'b0;
      if (handshake) begin
         if (rdFp)
            busyFp_d[issRd_q] = 1'b1;
         else if (!(X0_HARD && issRd_q == 5'd0))
            busyInt_d[issRd_q] = 1'b1;
      end
   end

   // Dispatch FSM with latched instruction, saturating stall counter and
   // scoreboard; flush overrides every state but keeps the scoreboard.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= EMPTY;
         issType_q  <= '0;
         issRd_q    <= '0;
         issRs1_q   <= '0;
         issRs2_q   <= '0;
         issRs3_q   <= '0;
         issRconf_q <= '0;
         stallCnt_q <= '0;
         busyInt_q  <= '0;
         busyFp_q   <= '0;
      end else begin
         busyInt_q <= busyInt_d;
         busyFp_q  <= busyFp_d;
         if (bus.flush_i) begin
            state_q <= EMPTY;
         end else begin
            case (state_q)
               EMPTY: begin
                  if (bus.dec_valid_i) begin
                     issType_q  <= bus.dec_type_i;
                     issRd_q    <= bus.dec_rd_i;
                     issRs1_q   <= bus.dec_rs1_i;
                     issRs2_q   <= bus.dec_rs2_i;
                     issRs3_q   <= bus.dec_rs3_i;
                     issRconf_q <= bus.dec_rconf_i;
                     state_q    <= decBad ? TRAP : WAIT;
                  end
               end
               WAIT: begin
                  if (hazard) begin
                     if (stallCnt_q != {CNT_W{1'b1}})
                        stallCnt_q <= stallCnt_q + 1'b1;
                  end else begin
                     state_q <= ISSUE;
                  end
               end
               ISSUE: begin
                  if (handshake)
                     state_q <= EMPTY;
               end
               TRAP: begin
                  state_q <= TRAP;
               end
               default: state_q <= EMPTY;
            endcase
         end
      end
   end

   assign bus.dec_ready_o  = n_rst && (state_q == EMPTY) && !bus.flush_i;
   assign bus.alu_valid_o  = n_rst && (state_q == ISSUE) && selAlu;
   assign bus.fpu_valid_o  = n_rst && (state_q == ISSUE) && selFpu;
   assign bus.mem_valid_o  = n_rst && (state_q == ISSUE) && selMem;
   assign bus.trap_valid_o = n_rst && (state_q == TRAP);
   assign bus.iss_type_o   = issType_q;
   assign bus.iss_rd_o     = issRd_q;
   assign bus.iss_rs1_o    = issRs1_q;
   assign bus.iss_rs2_o    = issRs2_q;
   assign bus.iss_rs3_o    = issRs3_q;
   assign bus.stall_cnt_o  = stallCnt_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed self-checking bench for issue_scheduler (4-bit stall counter so
// saturation is reachable quickly).
module tb_issue_scheduler;

   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   checksRun = 0;
   int   checksPassed = 0;

   issue_scheduler_if #(.CNT_W(CNT_W)) bus ();

   issue_scheduler #(.CNT_W(CNT_W), .X0_HARD(1'b1)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison: count it and report observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checksRun++;
      assert (observed === expected) checksPassed++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   // Present one instruction to the decoder port for a single accept cycle.
   task automatic applyStimulus(input logic [3:0] typ, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rs3, input logic [2:0] rconf,
                                input logic nBad);
      bus.dec_valid_i = 1'b1;
      bus.dec_type_i  = typ;
      bus.dec_rd_i    = rd;
      bus.dec_rs1_i   = rs1;
      bus.dec_rs2_i   = rs2;
      bus.dec_rs3_i   = rs3;
      bus.dec_rconf_i = rconf;
      bus.dec_n_bad_i = nBad;
      checkOutput("accept_dec_ready", 32'(bus.dec_ready_o), 32'd1);
      tick();
      bus.dec_valid_i = 1'b0;
      bus.dec_n_bad_i = 1'b1;
   endtask

   // Integer writeback strobe for one cycle.
   task automatic wbInt(input logic [4:0] rd);
      bus.wb_int_valid_i = 1'b1;
      bus.wb_int_rd_i    = rd;
      tick();
      bus.wb_int_valid_i = 1'b0;
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      bus.dec_valid_i = 0; bus.dec_type_i = 0; bus.dec_rd_i = 0;
      bus.dec_rs1_i = 0; bus.dec_rs2_i = 0; bus.dec_rs3_i = 0;
      bus.dec_rconf_i = 0; bus.dec_n_bad_i = 1; bus.flush_i = 0;
      bus.alu_ready_i = 0; bus.fpu_ready_i = 0; bus.mem_ready_i = 0;
      bus.wb_int_valid_i = 0; bus.wb_int_rd_i = 0;
      bus.wb_fp_valid_i = 0; bus.wb_fp_rd_i = 0;

      // reset
      tick(); tick();
      checkOutput("rst_dec_ready", 32'(bus.dec_ready_o), 32'd0);
      checkOutput("rst_alu_valid", 32'(bus.alu_valid_o), 32'd0);
      checkOutput("rst_trap", 32'(bus.trap_valid_o), 32'd0);
      checkOutput("rst_stall", 32'(bus.stall_cnt_o), 32'd0);
      checkOutput("rst_iss_rd", 32'(bus.iss_rd_o), 32'd0);
      n_rst = 1'b1;
      #1;
      checkOutput("idle_dec_ready", 32'(bus.dec_ready_o), 32'd1);

      // ALU add rd5 <- rs1,rs2
      applyStimulus(4'b1000, 5'd5, 5'd1, 5'd2, 5'd0, 3'b110, 1'b1);
      checkOutput("alu_wait_valid", 32'(bus.alu_valid_o), 32'd0);
      checkOutput("alu_wait_ready", 32'(bus.dec_ready_o), 32'd0);
      tick();
      checkOutput("alu_issue_valid", 32'(bus.alu_valid_o), 32'd1);
      checkOutput("alu_issue_fpu", 32'(bus.fpu_valid_o), 32'd0);
      checkOutput("alu_iss_rd", 32'(bus.iss_rd_o), 32'd5);
      checkOutput("alu_iss_rs1", 32'(bus.iss_rs1_o), 32'd1);
      checkOutput("alu_iss_type", 32'(bus.iss_type_o), 32'h8);
      bus.alu_ready_i = 1'b1;
      tick();
      bus.alu_ready_i = 1'b0;
      #1;
      checkOutput("alu_done_valid", 32'(bus.alu_valid_o), 32'd0);
      checkOutput("alu_busy5_set", 32'(dut.busyInt_q[5]), 32'd1);
      checkOutput("alu_done_ready", 32'(bus.dec_ready_o), 32'd1);

      // RAW on x5: three stall cycles, writeback in the third
      applyStimulus(4'b1000, 5'd6, 5'd5, 5'd0, 5'd0, 3'b100, 1'b1);
      tick();
      tick();
      checkOutput("raw_stall2", 32'(bus.stall_cnt_o), 32'd2);
      checkOutput("raw_hold_valid", 32'(bus.alu_valid_o), 32'd0);
      bus.wb_int_valid_i = 1'b1;
      bus.wb_int_rd_i    = 5'd5;
      tick();
      bus.wb_int_valid_i = 1'b0;
      checkOutput("raw_stall3", 32'(bus.stall_cnt_o), 32'd3);
      checkOutput("raw_busy5_clr", 32'(dut.busyInt_q[5]), 32'd0);
      checkOutput("raw_wb1_valid", 32'(bus.alu_valid_o), 32'd0);
      tick();
      checkOutput("raw_wb2_valid", 32'(bus.alu_valid_o), 32'd1);
      checkOutput("raw_iss_rd", 32'(bus.iss_rd_o), 32'd6);
      bus.alu_ready_i = 1'b1;
      tick();
      bus.alu_ready_i = 1'b0;
      wbInt(5'd6);
      checkOutput("raw_busy6_clr", 32'(dut.busyInt_q[6]), 32'd0);

      // FLW f3 <- x2 goes to MEM, marks FP file
      applyStimulus(4'b0101, 5'd3, 5'd2, 5'd0, 5'd0, 3'b100, 1'b1);
      tick();
      checkOutput("flw_mem_valid", 32'(bus.mem_valid_o), 32'd1);
      checkOutput("flw_fpu_valid", 32'(bus.fpu_valid_o), 32'd0);
      checkOutput("flw_alu_valid", 32'(bus.alu_valid_o), 32'd0);
      bus.mem_ready_i = 1'b1;
      tick();
      bus.mem_ready_i = 1'b0;
      checkOutput("flw_busyfp3", 32'(dut.busyFp_q[3]), 32'd1);
      checkOutput("flw_busyint3", 32'(dut.busyInt_q[3]), 32'd0);

      // rd=x0 is never marked busy
      applyStimulus(4'b1000, 5'd0, 5'd1, 5'd2, 5'd0, 3'b110, 1'b1);
      tick();
      bus.alu_ready_i = 1'b1;
      tick();
      bus.alu_ready_i = 1'b0;
      checkOutput("x0_not_busy", 32'(dut.busyInt_q[0]), 32'd0);

      // issue-set beats same-cycle writeback-clear
      applyStimulus(4'b1000, 5'd9, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1);
      tick();
      bus.alu_ready_i    = 1'b1;
      bus.wb_int_valid_i = 1'b1;
      bus.wb_int_rd_i    = 5'd9;
      tick();
      bus.alu_ready_i    = 1'b0;
      bus.wb_int_valid_i = 1'b0;
      checkOutput("setwins_busy9", 32'(dut.busyInt_q[9]), 32'd1);
      wbInt(5'd9);
      checkOutput("wb_busy9_clr", 32'(dut.busyInt_q[9]), 32'd0);

      // illegal instruction traps and holds until flush
      applyStimulus(4'b1000, 5'd1, 5'd1, 5'd1, 5'd1, 3'b000, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checkOutput("trap_hold_valid", 32'(bus.trap_valid_o), 32'd1);
         checkOutput("trap_hold_ready", 32'(bus.dec_ready_o), 32'd0);
         tick();
      end
      bus.flush_i = 1'b1;
      #1;
      checkOutput("trap_flush_ready", 32'(bus.dec_ready_o), 32'd0);
      tick();
      bus.flush_i = 1'b0;
      #1;
      checkOutput("trap_clr_valid", 32'(bus.trap_valid_o), 32'd0);
      checkOutput("trap_clr_ready", 32'(bus.dec_ready_o), 32'd1);

      // dec_type of zero also traps
      applyStimulus(4'b0000, 5'd1, 5'd1, 5'd1, 5'd1, 3'b000, 1'b1);
      checkOutput("type0_trap", 32'(bus.trap_valid_o), 32'd1);
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      #1;
      checkOutput("type0_clr", 32'(bus.trap_valid_o), 32'd0);

      // MEM stalled on ready, flushed on third issue cycle
      applyStimulus(4'b0001, 5'd7, 5'd1, 5'd0, 5'd0, 3'b100, 1'b1);
      tick();
      checkOutput("memfl_c1_valid", 32'(bus.mem_valid_o), 32'd1);
      tick();
      checkOutput("memfl_c2_valid", 32'(bus.mem_valid_o), 32'd1);
      checkOutput("memfl_c2_rd", 32'(bus.iss_rd_o), 32'd7);
      tick();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      #1;
      checkOutput("memfl_valid_drop", 32'(bus.mem_valid_o), 32'd0);
      checkOutput("memfl_busy7", 32'(dut.busyInt_q[7]), 32'd0);
      checkOutput("memfl_ready", 32'(bus.dec_ready_o), 32'd1);

      // flush together with ready still counts as issued
      applyStimulus(4'b0001, 5'd8, 5'd1, 5'd0, 5'd0, 3'b100, 1'b1);
      tick();
      bus.flush_i     = 1'b1;
      bus.mem_ready_i = 1'b1;
      tick();
      bus.flush_i     = 1'b0;
      bus.mem_ready_i = 1'b0;
      #1;
      checkOutput("flrdy_valid", 32'(bus.mem_valid_o), 32'd0);
      checkOutput("flrdy_busy8", 32'(dut.busyInt_q[8]), 32'd1);
      checkOutput("flrdy_ready", 32'(bus.dec_ready_o), 32'd1);
      checkOutput("pre_rst_stall", 32'(bus.stall_cnt_o), 32'd3);

      // reset in the middle of an ISSUE
      applyStimulus(4'b1000, 5'd10, 5'd1, 5'd0, 5'd0, 3'b100, 1'b1);
      tick();
      checkOutput("midrst_valid_pre", 32'(bus.alu_valid_o), 32'd1);
      n_rst = 1'b0;
      #1;
      checkOutput("midrst_valid_forced", 32'(bus.alu_valid_o), 32'd0);
      checkOutput("midrst_ready_forced", 32'(bus.dec_ready_o), 32'd0);
      tick();
      checkOutput("midrst_busyint", dut.busyInt_q, 32'd0);
      checkOutput("midrst_busyfp", dut.busyFp_q, 32'd0);
      checkOutput("midrst_stall", 32'(bus.stall_cnt_o), 32'd0);
      n_rst = 1'b1;
      #1;
      checkOutput("midrst_idle_ready", 32'(bus.dec_ready_o), 32'd1);
      checkOutput("midrst_alu_idle", 32'(bus.alu_valid_o), 32'd0);

      // stall counter saturates at all-ones
      applyStimulus(4'b1000, 5'd11, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1);
      tick();
      bus.alu_ready_i = 1'b1;
      tick();
      bus.alu_ready_i = 1'b0;
      applyStimulus(4'b1000, 5'd12, 5'd11, 5'd0, 5'd0, 3'b100, 1'b1);
      for (int i = 0; i < 14; i++) tick();
      checkOutput("sat_near", 32'(bus.stall_cnt_o), 32'd14);
      tick();
      checkOutput("sat_full", 32'(bus.stall_cnt_o), 32'd15);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("sat_hold", 32'(bus.stall_cnt_o), 32'd15);
      checkOutput("sat_no_valid", 32'(bus.alu_valid_o), 32'd0);
      wbInt(5'd11);
      tick();
      checkOutput("sat_release_valid", 32'(bus.alu_valid_o), 32'd1);
      checkOutput("sat_release_stall", 32'(bus.stall_cnt_o), 32'd15);
      bus.alu_ready_i = 1'b1;
      tick();
      bus.alu_ready_i = 1'b0;
      checkOutput("sat_busy12", 32'(dut.busyInt_q[12]), 32'd1);

      $display("%0d/%0d checks passed", checksPassed, checksRun);
      $finish;
   end

endmodule
